// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return pc & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small skid FIFO of fetch entries with combinational head, occupancy count,
// synchronous clear and asynchronous reset. FIFO_DEPTH must be 2 or 4.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  fetch_entry_t     entries [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (clear) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr          <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head  = entries[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, tracks the one-cycle memory
// latency and buffers returned words for decode. Optional FETCH_PERF_EN adds counters.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight_v;
  logic [ADDR_W-1:0] inflight_pc;

  logic [CNT_W-1:0]  fifo_count;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_entry;
  logic              push;
  logic              pop;
  logic              issue;
  logic [CNT_W:0]    occ_after_pop;

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign push      = inflight_v && !redirect_valid;

  // Credit check counts the in-flight word, so a push can never hit a full FIFO.
  assign occ_after_pop = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_v) - (CNT_W + 1)'(pop);
  assign issue         = !redirect_valid && (occ_after_pop < DEPTH_LIM);

  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = inflight_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight_v  <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc   <= align_pc(redirect_pc);
      inflight_v <= 1'b0;
    end else begin
      inflight_v <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(4);
      end
    end
  end

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  assign imem_addr = fetch_pc;

  // Stale storage stays hidden behind zeros whenever the FIFO is empty.
  assign out_instr = out_valid ? fifo_head.instr : NOP_INSTR;
  assign out_pc    = out_valid ? fifo_head.pc    : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (out_valid && !out_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`else
  assign perf_fetched = '0;
  assign perf_stall   = '0;
`endif

endmodule
